// File: rtl/mm_cmd_master.sv
// Avalon-MM command master: converts single-beat read/write commands into one
// bus transaction each and returns exactly one response per command. A
// waitrequest timeout aborts transactions the slave never acknowledges.
module mm_cmd_master #(
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    // command stream
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_address,
    input  logic [DW-1:0] cmd_writedata,
    // response stream
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_readdata,
    output logic          rsp_error,
    // Avalon-MM master
    output logic [AW-1:0] address,
    output logic          read,
    output logic          write,
    output logic [DW-1:0] writedata,
    input  logic [DW-1:0] readdata,
    input  logic          waitrequest,
    output logic          busy
);

    // Counter is wide enough to hold TIMEOUT; at least one bit when disabled.
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit            TimeoutEn = (TIMEOUT != 0);
    localparam logic [CW-1:0] CntLast   = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CntMax    = '1;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StRsp
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          read_q, read_d;
    logic          write_q, write_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;

    // Next-state and datapath: one bus transaction, then hold the response.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        read_d      = read_q;
        write_d     = write_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    addr_d  = cmd_address;
                    wdata_d = cmd_writedata;
                    read_d  = ~cmd_write;
                    write_d = cmd_write;
                    cnt_d   = '0;
                    state_d = StBus;
                end
            end
            StBus: begin
                if (!waitrequest) begin
                    // Completion wins over a timeout landing on the same edge.
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    rsp_data_d  = read_q ? readdata : '0;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = StRsp;
                end else begin
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    // Abort on the edge that ends the TIMEOUT-th strobe cycle.
                    if (TimeoutEn && (cnt_q == CntLast)) begin
                        read_d      = 1'b0;
                        write_d     = 1'b0;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = StRsp;
                    end
                end
            end
            StRsp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            read_q      <= read_d;
            write_q     <= write_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Outputs: everything registered except cmd_ready, which is gated by reset.
    always_comb begin
        cmd_ready    = reset_n & (state_q == StIdle);
        busy         = (state_q != StIdle);
        address      = addr_q;
        writedata    = wdata_q;
        read         = read_q;
        write        = write_q;
        rsp_valid    = rsp_valid_q;
        rsp_readdata = rsp_data_q;
        rsp_error    = rsp_err_q;
    end

endmodule

// File: tb/tb_mm_cmd_master.sv
// Self-checking bench for mm_cmd_master: directed steps from the test plan
// followed by randomized commands, checked against a memory-level model.
module tb_mm_cmd_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_address = '0;
    logic [15:0] cmd_writedata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_readdata;
    logic        rsp_error;
    logic [7:0]  address;
    logic        read;
    logic        write;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        waitrequest;
    logic        busy;

    int ntests = 0;
    int nfail  = 0;

    mm_cmd_master #(
        .AW(8),
        .DW(16),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_address(cmd_address),
        .cmd_writedata(cmd_writedata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_readdata(rsp_readdata),
        .rsp_error(rsp_error),
        .address(address),
        .read(read),
        .write(write),
        .writedata(writedata),
        .readdata(readdata),
        .waitrequest(waitrequest),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Slave: unwritten locations read back as their own address; waitrequest is
    // held high for wait_cfg cycles of each strobe.
    logic [15:0]  mem [256];
    logic [255:0] mem_wr = '0;
    int           wait_cfg = 0;
    int           scnt = 0;
    longint       cyc = 0;

    assign waitrequest = (scnt < wait_cfg);
    assign readdata    = mem_wr[address] ? mem[address] : {8'h00, address};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (read || write) scnt <= scnt + 1;
        else               scnt <= 0;
        if (write && !waitrequest) begin
            mem[address]    <= writedata;
            mem_wr[address] <= 1'b1;
        end
    end

    // Reference: expected memory contents after every completed write.
    logic [15:0] ref_mem [int];

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one command from an idle negedge and follow it to the idle cycle
    // after its response is consumed. acc returns the acceptance edge number.
    task automatic run_cmd(input logic wr, input logic [7:0] a, input logic [15:0] d,
                           input int waits, input int rdly, output longint acc);
        bit          tmo;
        int          slen;
        logic [15:0] exp_rd;
        tmo  = (waits >= TO);
        slen = tmo ? TO : waits + 1;
        if (wr || tmo)                 exp_rd = 16'h0000;
        else if (ref_mem.exists(int'(a))) exp_rd = ref_mem[int'(a)];
        else                           exp_rd = {8'h00, a};
        if (wr && !tmo) ref_mem[int'(a)] = d;

        chk_bit("idle_cmd_ready", cmd_ready, 1'b1);
        wait_cfg      = waits;
        cmd_valid     = 1'b1;
        cmd_write     = wr;
        cmd_address   = a;
        cmd_writedata = d;
        rsp_ready     = (rdly == 0);
        @(negedge clk);
        acc = cyc;
        // Scramble the idle command bus; the latched copy must not follow it.
        cmd_valid     = 1'b0;
        cmd_write     = 1'($urandom);
        cmd_address   = 8'($urandom);
        cmd_writedata = 16'($urandom);

        for (int i = 0; i < slen; i++) begin
            chk_bit("strobe_read", read, !wr);
            chk_bit("strobe_write", write, wr);
            chk_vec("bus_address", 16'(address), 16'(a));
            chk_vec("bus_writedata", writedata, d);
            chk_bit("bus_cmd_ready", cmd_ready, 1'b0);
            chk_bit("bus_rsp_valid", rsp_valid, 1'b0);
            chk_bit("bus_busy", busy, 1'b1);
            @(negedge clk);
        end

        chk_bit("rsp_read_clear", read, 1'b0);
        chk_bit("rsp_write_clear", write, 1'b0);
        chk_bit("rsp_valid", rsp_valid, 1'b1);
        chk_vec("rsp_readdata", rsp_readdata, exp_rd);
        chk_bit("rsp_error", rsp_error, tmo);
        chk_bit("rsp_cmd_ready", cmd_ready, 1'b0);

        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            chk_bit("hold_rsp_valid", rsp_valid, 1'b1);
            chk_vec("hold_readdata", rsp_readdata, exp_rd);
            chk_bit("hold_error", rsp_error, tmo);
            chk_bit("hold_cmd_ready", cmd_ready, 1'b0);
            chk_bit("hold_no_strobe", read | write, 1'b0);
        end

        rsp_ready = 1'b1;
        @(negedge clk);
        chk_bit("done_rsp_valid", rsp_valid, 1'b0);
        chk_bit("done_busy", busy, 1'b0);
    endtask

    initial begin
        longint a0, a1, a2;

        // Reset state, including combinational cmd_ready while in reset.
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_bit("rst_read", read, 1'b0);
        chk_bit("rst_write", write, 1'b0);
        chk_vec("rst_address", 16'(address), 16'h0000);
        chk_vec("rst_writedata", writedata, 16'h0000);
        chk_bit("rst_rsp_valid", rsp_valid, 1'b0);
        chk_vec("rst_rsp_readdata", rsp_readdata, 16'h0000);
        chk_bit("rst_rsp_error", rsp_error, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_cmd_ready", cmd_ready, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        // Zero-wait read, then a write with three wait cycles.
        run_cmd(1'b0, 8'h01, 16'h0000, 0, 0, a0);
        run_cmd(1'b1, 8'h01, 16'hA5A5, 3, 0, a0);

        // Back-to-back reads with rsp_ready held high: one command per 3 cycles.
        run_cmd(1'b0, 8'h02, 16'h0000, 0, 0, a0);
        run_cmd(1'b0, 8'h03, 16'h0000, 0, 0, a1);
        run_cmd(1'b0, 8'h03, 16'h0000, 0, 0, a2);
        chk_vec("b2b_period_1", 16'(a1 - a0), 16'd3);
        chk_vec("b2b_period_2", 16'(a2 - a1), 16'd3);

        // Response backpressure.
        run_cmd(1'b0, 8'h03, 16'h0000, 0, 5, a0);

        // Timeout with waitrequest stuck, then completion on the last allowed cycle.
        run_cmd(1'b0, 8'h04, 16'h0000, 100, 0, a0);
        run_cmd(1'b0, 8'h04, 16'h0000, TO - 1, 0, a0);
        run_cmd(1'b0, 8'h04, 16'h0000, TO, 1, a0);

        // Earlier write is visible to a later read.
        run_cmd(1'b0, 8'h01, 16'h0000, 2, 0, a0);

        // Reset during a stalled write: strobe drops, nothing is written.
        wait_cfg      = 100;
        cmd_valid     = 1'b1;
        cmd_write     = 1'b1;
        cmd_address   = 8'h10;
        cmd_writedata = 16'h1234;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk_bit("stall_write", write, 1'b1);
        reset_n = 1'b0;
        @(negedge clk);
        chk_bit("midrst_write", write, 1'b0);
        chk_bit("midrst_rsp_valid", rsp_valid, 1'b0);
        chk_bit("midrst_busy", busy, 1'b0);
        chk_bit("midrst_cmd_ready", cmd_ready, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        run_cmd(1'b0, 8'h10, 16'h0000, 0, 0, a0);

        // Randomized traffic over a small address window so reads hit writes.
        for (int n = 0; n < 40; n++) begin
            run_cmd(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom),
                    int'($urandom_range(0, 10)), int'($urandom_range(0, 3)), a0);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/mm_cmd_master.md
Name: mm_cmd_master

Overview:
- Avalon-MM master stage that sits directly upstream of the `mm` slave (8-bit address, 16-bit data, waitrequest flow control).
- Accepts single-beat read/write commands on a valid/ready command stream.
- Drives one bus transaction per command, holding the strobe and address while waitrequest is high.
- Returns exactly one response per command (read data, or write acknowledge) on a valid/ready response stream. A timeout aborts transactions the slave never acknowledges.

Parameters:
- AW, 8: address width.
- DW, 16: data width.
- TIMEOUT, 255: waitrequest cycles tolerated before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a clk edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_address  in  AW  target address.
- cmd_writedata  in  DW  write payload.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at a clk edge.
- rsp_readdata  out  DW  read data; 0 for writes and for aborted transactions.
- rsp_error  out  1  transaction aborted by timeout.
- address  out  AW  Avalon address.
- read  out  1  Avalon read strobe.
- write  out  1  Avalon write strobe.
- writedata  out  DW  Avalon write data.
- readdata  in  DW  Avalon read data, valid in the cycle waitrequest is low with read high.
- waitrequest  in  1  Avalon stall.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset_n is synchronous and active-low, sampled at the clk rising edge.
- Reset values, applied at any clk edge with reset_n = 0:
  - state = IDLE; read = write = 0; address = 0; writedata = 0.
  - rsp_valid = 0, rsp_readdata = 0, rsp_error = 0; timeout counter = 0.
  - cmd_ready is combinationally 0 while reset_n = 0.
- State IDLE:
  - cmd_ready = 1.
  - On acceptance at edge N: latch address and writedata; set read = ~cmd_write, write = cmd_write; clear the counter; go to BUS.
  - The strobe is visible in the cycle after edge N.
- State BUS:
  - cmd_ready = 0. address, writedata, read and write are held stable.
  - At an edge with waitrequest = 0, the transaction completes:
    - read/write clear;
    - for a read, rsp_readdata <= readdata; for a write, rsp_readdata <= 0;
    - rsp_error <= 0; rsp_valid <= 1; go to RSP.
  - At an edge with waitrequest = 1, the counter increments. If TIMEOUT != 0 and the counter equals TIMEOUT - 1 at that edge, the transaction aborts:
    - strobes clear; rsp_error <= 1; rsp_readdata <= 0; rsp_valid <= 1; go to RSP.
    - The strobe is therefore asserted for exactly TIMEOUT cycles.
  - Completion takes priority over timeout on the same edge.
- State RSP:
  - rsp_valid, rsp_readdata and rsp_error are held until rsp_ready = 1 at an edge; then rsp_valid <= 0 and the state returns to IDLE.
  - cmd_ready = 0 throughout RSP; the next command cannot be accepted before the IDLE cycle that follows.
- Latency:
  - With a zero-wait slave: strobe high 1 cycle; rsp_valid rises 2 edges after acceptance.
  - Each waitrequest cycle adds 1 cycle.
  - Minimum command period is 3 cycles with rsp_ready held at 1.
- Strobe rules:
  - read and write are never high together.
  - A strobe never drops while waitrequest = 1, except on timeout abort or reset.
- Reset mid-operation: strobes clear at the reset edge and any pending response is discarded (rsp_valid = 0).
- Counter width is clog2(TIMEOUT + 1), minimum 1; the counter saturates and never wraps.

Test Plan:
- Read, zero-wait slave: cmd (read, addr 0x01) accepted at edge N -> read = 1 with address 0x01 for 1 cycle; readdata = 0x0001; at edge N+2, rsp_valid = 1, rsp_readdata = 0x0001, rsp_error = 0.
- Write with 3 wait cycles: cmd (write, addr 0x01, data 0xA5A5) -> write = 1, address = 0x01, writedata = 0xA5A5 stable for 4 cycles; then rsp_valid = 1, rsp_readdata = 0x0000.
- Back-to-back reads, rsp_ready held at 1: reads of 0x02, then 0x03, then 0x03 -> three responses 0x0002, 0x0003, 0x0003 in order, commands accepted 3 cycles apart, no overlapping strobes.
- Response backpressure: rsp_ready = 0 for 5 cycles after a read of 0x03 -> rsp_valid and rsp_readdata = 0x0003 held, cmd_ready = 0, no new strobe; release -> IDLE on the next edge.
- Timeout, TIMEOUT = 8, waitrequest stuck at 1: read 0x04 -> read high exactly 8 cycles, then rsp_error = 1, rsp_readdata = 0. Repeat with waitrequest falling on cycle 8 -> normal completion, rsp_error = 0.
- Reset mid-BUS: reset_n = 0 for 1 edge during a stalled write -> write = 0, rsp_valid = 0, busy = 0 after that edge; the next command executes normally.
